// File: rtl/seg7_hex_display.sv
// Eight-digit multiplexed hex display driver for common-anode seven-segment digits.
// Captures a shadow copy of the output word on a strobe and scans one digit per slot.
module seg7_hex_display #(
  parameter int unsigned REFRESH_DIV  = 100000,
  parameter int unsigned BLANK_CYCLES = 16
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] data_i,
  input  logic        data_vld_i,
  input  logic [7:0]  mask_i,
  input  logic        blank_lz_i,
  output logic [7:0]  an_o,
  output logic [6:0]  seg_o,
  output logic        dp_o
);

  localparam int unsigned CNT_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;

  logic [31:0]      shadow_q, shadow_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       idx_q, idx_d;
  logic [7:0]       an_q, an_d;
  logic [6:0]       seg_q, seg_d;

  logic       in_dead;
  logic       slot_end;
  logic [3:0] nibble;
  logic [7:0] lead_zero;
  logic       upper_zero;

  function automatic logic [6:0] glyph(input logic [3:0] val);
    logic [6:0] g;
    case (val)
      4'h0: g = 7'b1000000;
      4'h1: g = 7'b1111001;
      4'h2: g = 7'b0100100;
      4'h3: g = 7'b0110000;
      4'h4: g = 7'b0011001;
      4'h5: g = 7'b0010010;
      4'h6: g = 7'b0000010;
      4'h7: g = 7'b1111000;
      4'h8: g = 7'b0000000;
      4'h9: g = 7'b0010000;
      4'hA: g = 7'b0001000;
      4'hB: g = 7'b0000011;
      4'hC: g = 7'b1000110;
      4'hD: g = 7'b0100001;
      4'hE: g = 7'b0000110;
      default: g = 7'b0001110;
    endcase
    return g;
  endfunction

  if (BLANK_CYCLES == 0) begin : g_no_dead
    assign in_dead = 1'b0;
  end else begin : g_dead
    assign in_dead = (cnt_q < CNT_W'(BLANK_CYCLES));
  end

  assign slot_end = (cnt_q == CNT_W'(REFRESH_DIV - 1));
  assign nibble   = shadow_q[{idx_q, 2'b00} +: 4];

  // Digit k is a leading zero when nibbles k..7 are all zero; digit 0 always shows.
  always_comb begin
    // NOTE: every variable written here gets a default first so no latch is inferred;
    // blocking assignments are correct in combinational logic because later lines
    // must see the value just computed (upper_zero accumulates across iterations).
    lead_zero  = '0;
    upper_zero = 1'b1;
    for (int k = 7; k >= 1; k--) begin
      upper_zero   = upper_zero & (shadow_q[4*k +: 4] == 4'h0);
      lead_zero[k] = blank_lz_i & upper_zero;
    end
  end

  always_comb begin
    shadow_d = data_vld_i ? data_i : shadow_q;
    cnt_d    = slot_end ? '0 : cnt_q + CNT_W'(1);
    idx_d    = slot_end ? idx_q + 3'd1 : idx_q;

    an_d  = 8'hFF;
    seg_d = 7'h7F;
    if (!in_dead && mask_i[idx_q] && !lead_zero[idx_q]) begin
      an_d        = 8'hFF;
      an_d[idx_q] = 1'b0;
      seg_d       = glyph(nibble);
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples
    // the pre-edge values of the others, independent of statement order.
    if (!rst_i) begin
      shadow_q <= '0;
      cnt_q    <= '0;
      idx_q    <= '0;
      an_q     <= 8'hFF;
      seg_q    <= 7'h7F;
    end else begin
      shadow_q <= shadow_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      an_q     <= an_d;
      seg_q    <= seg_d;
    end
  end

  assign an_o  = an_q;
  assign seg_o = seg_q;
  assign dp_o  = 1'b1;

endmodule

// File: tb/tb_seg7_hex_display.sv
// Scoreboard bench for seg7_hex_display: driver pushes predicted outputs per cycle,
// monitor pops and compares them after every clock edge.
module tb_seg7_hex_display;

  localparam int RD = 4;
  localparam int BC = 1;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic [31:0] data_i = '0;
  logic        data_vld_i = 1'b0;
  logic [7:0]  mask_i = 8'hFF;
  logic        blank_lz_i = 1'b0;
  logic [7:0]  an_o;
  logic [6:0]  seg_o;
  logic        dp_o;

  seg7_hex_display #(.REFRESH_DIV(RD), .BLANK_CYCLES(BC)) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .data_i     (data_i),
    .data_vld_i (data_vld_i),
    .mask_i     (mask_i),
    .blank_lz_i (blank_lz_i),
    .an_o       (an_o),
    .seg_o      (seg_o),
    .dp_o       (dp_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [7:0] an;
    logic [6:0] seg;
  } exp_t;

  exp_t exp_q[$];

  int checks = 0;
  int errors = 0;

  // Active-low {g..a} patterns for hex digits 0..F.
  logic [6:0] glyph_tab [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  // Model state: cycles since reset release and captured word.
  int          m_t = 0;
  logic [31:0] m_shadow = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  // Called at a negedge: applies inputs for the coming posedge and predicts its result.
  task automatic cycle(input logic [31:0] d, input logic vld, input logic [7:0] m, input logic blz);
    exp_t e;
    int   cnt, idx;
    logic [31:0] upper;
    data_i = d; data_vld_i = vld; mask_i = m; blank_lz_i = blz;
    cnt   = m_t % RD;
    idx   = (m_t / RD) % 8;
    upper = m_shadow >> (4 * idx);
    e.an  = 8'hFF;
    e.seg = 7'h7F;
    if (cnt >= BC && m[idx] && !(blz && idx != 0 && upper == 0)) begin
      e.an  = ~(8'(1) << idx);
      e.seg = glyph_tab[upper & 32'hF];
    end
    exp_q.push_back(e);
    if (vld) m_shadow = d;
    m_t++;
    @(negedge clk_i);
  endtask

  task automatic run(input int n, input logic [7:0] m, input logic blz);
    for (int i = 0; i < n; i++) cycle(32'hDEAD_BEEF ^ i, 1'b0, m, blz);
  endtask

  // Asserts reset mid-cycle, checks the immediate effect, releases at a negedge.
  task automatic do_reset(input string tag);
    @(posedge clk_i);
    #3;
    rst_i = 1'b0;
    #1;
    check({tag, "_an_async"}, 32'(an_o), 32'hFF);
    check({tag, "_seg_async"}, 32'(seg_o), 32'h7F);
    check({tag, "_dp_async"}, 32'(dp_o), 32'h1);
    repeat (3) begin
      @(negedge clk_i);
      check({tag, "_an_hold"}, 32'(an_o), 32'hFF);
    end
    rst_i    = 1'b1;
    m_t      = 0;
    m_shadow = '0;
  endtask

  // Monitor: compares each registered output against the oldest prediction.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk_i);
      #1;
      if (rst_i) begin
        check("an_onehot", 32'($countones(~an_o) <= 1), 32'h1);
        check("dp_off", 32'(dp_o), 32'h1);
      end
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("an", 32'(an_o), 32'(e.an));
        check("seg", 32'(seg_o), 32'(e.seg));
      end
    end
  end

  initial begin
    repeat (2) @(negedge clk_i);
    check("rst_an", 32'(an_o), 32'hFF);
    check("rst_seg", 32'(seg_o), 32'h7F);
    check("rst_dp", 32'(dp_o), 32'h1);
    rst_i = 1'b1;

    // Scan order with descending nibbles.
    cycle(32'h0123_4567, 1'b1, 8'hFF, 1'b0);
    run(40, 8'hFF, 1'b0);

    // Reset in the middle of a scan.
    do_reset("mid");
    run(12, 8'hFF, 1'b0);
    cycle(32'h0000_00A0, 1'b1, 8'hFF, 1'b1);
    run(36, 8'hFF, 1'b1);
    cycle(32'h0000_0000, 1'b1, 8'hFF, 1'b1);
    run(36, 8'hFF, 1'b1);

    // Masking.
    cycle(32'h8888_8888, 1'b1, 8'h81, 1'b0);
    run(36, 8'h81, 1'b0);

    // Capture timing: strobe F with digit 0 active, then change data without strobe.
    do_reset("cap");
    cycle(32'h0000_000F, 1'b1, 8'hFF, 1'b0);
    cycle(32'h0000_0003, 1'b0, 8'hFF, 1'b0);
    run(6, 8'hFF, 1'b0);

    // Full glyph sweep, each word over a complete scan.
    cycle(32'hFEDC_BA98, 1'b1, 8'hFF, 1'b0);
    run(33, 8'hFF, 1'b0);
    cycle(32'h7654_3210, 1'b1, 8'hFF, 1'b0);
    run(33, 8'hFF, 1'b0);

    // Randomized traffic: sparse strobes, varying mask and blanking, back-to-back strobes.
    for (int i = 0; i < 400; i++) begin
      logic [31:0] d;
      d = $urandom;
      if ($urandom_range(0, 2) == 0) d = d >> (4 * $urandom_range(1, 8));
      cycle(d, $urandom_range(0, 3) == 0,
            ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'hFF,
            1'($urandom_range(0, 1)));
    end

    @(posedge clk_i);
    #2;
    check("queue_drained", 32'(exp_q.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
